// File: rtl/twiddle_product_stage.sv
// Multiplies each accepted complex sample by its bin twiddle W^(n*k mod N), round/scale/saturate to 16-bit {re,im}.
// Latency 3 cycles from accept edge to prod_out; no backpressure, input gaps appear as prod_valid=0.
module twiddle_product_stage #(
  parameter int N     = 64,
  parameter int BIN_W = 6,
  parameter int FRAC  = 14,
  parameter int SCALE = 0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [31:0]      sample_in,
  input  logic             sample_valid,
  input  logic             frame_start,
  input  logic [BIN_W-1:0] bin_k,
  output logic [BIN_W-1:0] tw_addr,
  input  logic [31:0]      tw_data,
  output logic [31:0]      prod_out,
  output logic             prod_valid,
  output logic             prod_first,
  output logic             prod_last,
  output logic             overrun
);

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx_t;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } meta_t;

  typedef enum logic {IDLE, RUN} state_t;

  localparam int SH = FRAC + SCALE;
  localparam logic signed [33:0] RND = 34'sd1 <<< (SH - 1);

  state_t           state_q, state_d;
  logic [BIN_W-1:0] k_q, phase_q, n_q;
  logic             start_acc, run_acc, drop, is_last;

  cplx_t            s0_dat, s1_dat, tw;
  meta_t            m0, m1, m2;
  logic signed [31:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [33:0] sum_re, sum_im, sh_re, sh_im;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_acc)    state_d = RUN;
    else if (is_last) state_d = IDLE;
  end

  // A frame_start with a valid sample restarts the frame from either state.
  always_comb begin
    start_acc = sample_valid & frame_start;
    run_acc   = 1'b0;
    drop      = 1'b0;
    case (state_q)
      IDLE: drop    = sample_valid & ~frame_start;
      RUN:  run_acc = sample_valid & ~frame_start;
      default: ;
    endcase
    is_last = run_acc && (n_q == BIN_W'(N - 1));
  end

  // E0: accept edge
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      k_q     <= '0;
      phase_q <= '0;
      n_q     <= '0;
      tw_addr <= '0;
      s0_dat  <= '0;
      m0      <= '0;
      overrun <= 1'b0;
    end else begin
      m0 <= '{vld: start_acc | run_acc, first: start_acc, last: is_last};
      if (start_acc) begin
        k_q     <= bin_k;
        phase_q <= bin_k;
        n_q     <= BIN_W'(1);
        tw_addr <= '0;
        s0_dat  <= sample_in;
      end else if (run_acc) begin
        tw_addr <= phase_q;
        phase_q <= phase_q + k_q;
        n_q     <= n_q + BIN_W'(1);
        s0_dat  <= sample_in;
      end
      if (start_acc)  overrun <= 1'b0;
      else if (drop)  overrun <= 1'b1;
    end
  end

  assign tw = cplx_t'(tw_data);

  // E1 aligns the sample with the ROM read; E2 registers the partial products.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_dat <= '0;
      m1     <= '0;
      m2     <= '0;
      p_rr   <= '0;
      p_ii   <= '0;
      p_ri   <= '0;
      p_ir   <= '0;
    end else begin
      s1_dat <= s0_dat;
      m1     <= m0;
      m2     <= m1;
      p_rr   <= s1_dat.re * tw.re;
      p_ii   <= s1_dat.im * tw.im;
      p_ri   <= s1_dat.re * tw.im;
      p_ir   <= s1_dat.im * tw.re;
    end
  end

  function automatic logic [15:0] sat16(input logic signed [33:0] v);
    if (v > 34'sd32767)       return 16'h7FFF;
    else if (v < -34'sd32768) return 16'h8000;
    else                      return v[15:0];
  endfunction

  always_comb begin
    sum_re = 34'(p_rr) - 34'(p_ii);
    sum_im = 34'(p_ri) + 34'(p_ir);
    sh_re  = (sum_re + RND) >>> SH;
    sh_im  = (sum_im + RND) >>> SH;
  end

  // E3: prod_out only moves on valid so it holds through gaps.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      prod_out   <= '0;
      prod_valid <= 1'b0;
      prod_first <= 1'b0;
      prod_last  <= 1'b0;
    end else begin
      prod_valid <= m2.vld;
      prod_first <= m2.vld & m2.first;
      prod_last  <= m2.vld & m2.last;
      if (m2.vld) prod_out <= {sat16(sh_re), sat16(sh_im)};
    end
  end

endmodule

// File: tb/tb_twiddle_product_stage.sv
// Scoreboard bench: directed stimulus pushes hand-derived products; negedge monitors pop and compare.
module tb_twiddle_product_stage;

  typedef struct {
    logic [31:0] dat;
    logic        first;
    logic        last;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [31:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [5:0]  bin_k = '0;
  logic        s2_en = 1'b0;
  logic        s2_valid;

  logic [5:0]  tw_addr0, tw_addr2;
  logic [31:0] tw_data0, tw_data2;
  logic [31:0] prod_out0, prod_out2;
  logic        prod_valid0, prod_first0, prod_last0, overrun0;
  logic        prod_valid2, prod_first2, prod_last2, overrun2;

  logic [31:0] rom [0:63];
  exp_t        q0[$];
  exp_t        q2[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  assign s2_valid = sample_valid & s2_en;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    tw_data0 <= rom[tw_addr0];
    tw_data2 <= rom[tw_addr2];
  end

  twiddle_product_stage #(.N(64), .BIN_W(6), .FRAC(14), .SCALE(0)) dut (
    .clk(clk), .nrst(nrst), .sample_in(sample_in), .sample_valid(sample_valid),
    .frame_start(frame_start), .bin_k(bin_k), .tw_addr(tw_addr0), .tw_data(tw_data0),
    .prod_out(prod_out0), .prod_valid(prod_valid0), .prod_first(prod_first0),
    .prod_last(prod_last0), .overrun(overrun0)
  );

  twiddle_product_stage #(.N(64), .BIN_W(6), .FRAC(14), .SCALE(2)) dut_s2 (
    .clk(clk), .nrst(nrst), .sample_in(sample_in), .sample_valid(s2_valid),
    .frame_start(frame_start), .bin_k(bin_k), .tw_addr(tw_addr2), .tw_data(tw_data2),
    .prod_out(prod_out2), .prod_valid(prod_valid2), .prod_first(prod_first2),
    .prod_last(prod_last2), .overrun(overrun2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (nrst && prod_valid0) begin
      if (q0.size() == 0) chk("p0_unexpected_valid", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        chk("p0_dat", prod_out0, e.dat);
        chk("p0_first_last", {30'd0, prod_first0, prod_last0}, {30'd0, e.first, e.last});
        chk("p0_latency_cyc", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (nrst && prod_valid2) begin
      if (q2.size() == 0) chk("p2_unexpected_valid", 32'd1, 32'd0);
      else begin
        e = q2.pop_front();
        chk("p2_dat", prod_out2, e.dat);
        chk("p2_first_last", {30'd0, prod_first2, prod_last2}, {30'd0, e.first, e.last});
        chk("p2_latency_cyc", cyc, e.cyc);
      end
    end
  end

  // Output appears at the negedge after accept edge + 3 pipeline edges.
  task automatic send(input logic [31:0] s, input logic fs, input logic [5:0] k,
                      input logic want, input logic [31:0] ed, input logic ef, input logic el);
    @(negedge clk);
    sample_in    = s;
    sample_valid = 1'b1;
    frame_start  = fs;
    bin_k        = k;
    if (want) q0.push_back('{ed, ef, el, cyc + 4});
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    sample_valid = 1'b0;
    frame_start  = 1'b0;
    s2_en        = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q0.size() != 0 || q2.size() != 0) && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", q0.size() + q2.size(), 32'd0);
    q0.delete();
    q2.delete();
  endtask

  logic [31:0] vec_tw [0:3] = '{32'h0000_C000, 32'h4000_4000, 32'h4000_0000, 32'h2000_0000};
  logic [31:0] vec_s  [0:3] = '{32'h0100_0200, 32'h7FFF_7FFF, 32'h8000_0000, 32'h0001_0000};
  logic [31:0] vec_e  [0:3] = '{32'h0200_FF00, 32'h0000_7FFF, 32'h8000_0000, 32'h0001_0000};
  logic [31:0] sc_s   [0:1] = '{32'h0100_0000, 32'h0002_0000};
  logic [31:0] sc_e2  [0:1] = '{32'h0040_0000, 32'h0001_0000};

  initial begin
    int m;
    for (int i = 0; i < 64; i++) rom[i] = {16'(32'h4000 - i * 256), 16'h0000};

    repeat (2) @(negedge clk);
    chk("rst_tw_addr", {26'd0, tw_addr0}, 32'd0);
    chk("rst_prod_out", prod_out0, 32'd0);
    chk("rst_flags", {28'd0, prod_valid0, prod_first0, prod_last0, overrun0}, 32'd0);
    chk("rst_s2_flags", {28'd0, prod_valid2, prod_first2, prod_last2, overrun2}, 32'd0);
    nrst = 1'b1;
    idle(2);

    // Identity frame: m is always 0 -> 0x4000_0000
    for (int i = 0; i < 64; i++)
      send(32'h0100_0200, i == 0, 6'd0, 1'b1, 32'h0100_0200, i == 0, i == 63);
    idle(2);
    drain();

    // Phase wrap with k=5 and address-dependent ROM contents
    for (int i = 0; i < 64; i++) begin
      m = (5 * i) % 64;
      send(32'h4000_0000, i == 0, 6'd5, 1'b1, {16'(32'h4000 - m * 256), 16'h0000}, i == 0, i == 63);
      @(posedge clk);
      #1 chk("tw_addr_wrap", {26'd0, tw_addr0}, m);
    end
    send(32'h4000_0000, 1'b0, 6'd5, 1'b0, 32'd0, 1'b0, 1'b0);
    idle(2);
    chk("overrun_set_idle", {31'd0, overrun0}, 32'd1);
    chk("tw_addr_hold", {26'd0, tw_addr0}, 32'd59);
    drain();

    // Restart at n=20: 20 old products, then a new first frame with k=0
    for (int i = 0; i < 20; i++) begin
      m = (3 * i) % 64;
      send(32'h4000_0000, i == 0, 6'd3, 1'b1, {16'(32'h4000 - m * 256), 16'h0000}, i == 0, 1'b0);
      if (i == 0) begin
        @(posedge clk);
        #1 chk("overrun_cleared", {31'd0, overrun0}, 32'd0);
      end
    end
    for (int i = 0; i < 64; i++)
      send(32'h4000_0000, i == 0, 6'd0, 1'b1, 32'h4000_0000, i == 0, i == 63);
    idle(2);
    drain();

    // Directed arithmetic vectors, each as a one-sample restart with k=0
    for (int i = 0; i < 4; i++) begin
      rom[0] = vec_tw[i];
      send(vec_s[i], 1'b1, 6'd0, 1'b1, vec_e[i], 1'b1, 1'b0);
      idle(1);
      drain();
    end

    // SCALE=2 instance alongside the SCALE=0 one
    rom[0] = 32'h4000_0000;
    for (int i = 0; i < 2; i++) begin
      s2_en = 1'b1;
      send(sc_s[i], 1'b1, 6'd0, 1'b1, sc_s[i], 1'b1, 1'b0);
      q2.push_back('{sc_e2[i], 1'b1, 1'b0, cyc + 4});
      idle(1);
      drain();
    end

    // Async reset mid-frame, between clock edges
    for (int i = 0; i < 10; i++)
      send(32'h0100_0200, i == 0, 6'd0, 1'b1, 32'h0100_0200, i == 0, 1'b0);
    @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("arst_tw_addr", {26'd0, tw_addr0}, 32'd0);
    chk("arst_prod_out", prod_out0, 32'd0);
    chk("arst_flags", {28'd0, prod_valid0, prod_first0, prod_last0, overrun0}, 32'd0);
    q0.delete();
    q2.delete();
    sample_valid = 1'b0;
    frame_start  = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    idle(1);

    for (int i = 0; i < 64; i++)
      send(32'h0100_0200, i == 0, 6'd0, 1'b1, 32'h0100_0200, i == 0, i == 63);
    idle(2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
